matrix_calc_sequencer: RTL and testbench

- Sequenced 3x3 matrix calculator. Accepts one request (matrices A and B plus an opcode) over a valid/ready handshake.
- Computes the result element by element on a single shared 16-bit multiply-accumulate lane, then presents the packed 144-bit result over a valid/ready handshake.
- Sits between the matrix-operation issuer and the result consumer. It replaces the flat combinational calculator wherever area matters more than latency.

---
 rtl/matrix_calc_pkg.sv | 21 ++
 rtl/matrix_calc_sequencer_if.sv | 28 ++
 rtl/matrix_mac_lane.sv | 28 ++
 rtl/matrix_calc_sequencer.sv | 129 ++++++++++++
 tb/tb_matrix_calc_sequencer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/matrix_calc_pkg.sv
// Shared opcodes, sequencer states and the packed-element addressing helper
// for the sequenced 3x3 matrix calculator.
package matrix_calc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_TRN = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Row-major packing with element 0 in the MSBs: returns the LSB of element e
  function automatic int elem_lsb(input int e, input int dim, input int dw);
    return (dim * dim - 1 - e) * dw;
  endfunction

endpackage

// File: rtl/matrix_calc_sequencer_if.sv
// Request/result handshake bundle between issuer, sequencer and consumer.
interface matrix_calc_sequencer_if #(
  parameter int DW  = 16,
  parameter int DIM = 3
);
  localparam int W = DIM * DIM * DW;

  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         busy;

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, busy
  );

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

endinterface

// File: rtl/matrix_mac_lane.sv
// Single shared DW-bit arithmetic lane: multiply-accumulate for MUL,
// elementwise add/sub, and pass-through of a for TRANSPOSE.
module matrix_mac_lane
  import matrix_calc_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] acc,
  input  logic [1:0]    op,
  output logic [DW-1:0] y
);

  logic [DW-1:0] prod;

  // Product is truncated to DW bits before it joins the accumulator
  always_comb begin
    prod = a * b;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = acc + prod;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/matrix_calc_sequencer.sv
// Sequenced matrix calculator: captures one request, walks the elements on a
// single shared lane, then holds the packed result until the consumer takes it.
module matrix_calc_sequencer
  import matrix_calc_pkg::*;
#(
  parameter int DW  = 16,
  parameter int DIM = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  matrix_calc_sequencer_if.slave  bus
);

  localparam int W  = DIM * DIM * DW;
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] lane_a, lane_b, lane_y;
  logic          last_elem;

  // MUL walks a(i,k)*b(k,j); the elementwise ops address element (i,j) directly
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    if (op_q == OP_MUL) begin
      lane_a = a_q[elem_lsb(int'(i_q) * DIM + int'(k_q), DIM, DW) +: DW];
      lane_b = b_q[elem_lsb(int'(k_q) * DIM + int'(j_q), DIM, DW) +: DW];
    end else if (op_q == OP_TRN) begin
      lane_a = a_q[elem_lsb(int'(j_q) * DIM + int'(i_q), DIM, DW) +: DW];
    end else begin
      lane_a = a_q[elem_lsb(int'(i_q) * DIM + int'(j_q), DIM, DW) +: DW];
      lane_b = b_q[elem_lsb(int'(i_q) * DIM + int'(j_q), DIM, DW) +: DW];
    end
  end

  matrix_mac_lane #(.DW(DW)) u_lane (
    .a   (lane_a),
    .b   (lane_b),
    .acc (acc_q),
    .op  (op_q),
    .y   (lane_y)
  );

  assign last_elem = (i_q == CW'(DIM - 1)) && (j_q == CW'(DIM - 1));

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          op_d    = bus.in_op;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if ((op_q == OP_MUL) && (k_q != CW'(DIM - 1))) begin
          acc_d = lane_y;
          k_d   = k_q + CW'(1);
        end else begin
          res_d[elem_lsb(int'(i_q) * DIM + int'(j_q), DIM, DW) +: DW] = lane_y;
          acc_d = '0;
          k_d   = '0;
          if (j_q == CW'(DIM - 1)) begin
            j_d = '0;
            i_d = i_q + CW'(1);
          end else begin
            j_d = j_q + CW'(1);
          end
          if (last_elem) begin
            i_d     = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_result = res_q;

endmodule

// File: tb/tb_matrix_calc_sequencer.sv
// Directed scoreboard bench for matrix_calc_sequencer: expected matrices are
// queued at request time and popped when the result handshake completes.
module tb_matrix_calc_sequencer;
  import matrix_calc_pkg::*;

  localparam int DW  = 16;
  localparam int DIM = 3;
  localparam int W   = DIM * DIM * DW;

  localparam logic [W-1:0] MAT_A = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
  localparam logic [W-1:0] MAT_B = {16'd7, 16'd3, 16'd5, 16'd12, 16'd11, 16'd17, 16'd20, 16'd3, 16'd0};
  localparam logic [W-1:0] EXP_MUL = {16'd91, 16'd34, 16'd39, 16'd208, 16'd85, 16'd105, 16'd325, 16'd136, 16'd171};
  localparam logic [W-1:0] EXP_ADD = {16'd8, 16'd5, 16'd8, 16'd16, 16'd16, 16'd23, 16'd27, 16'd11, 16'd9};
  localparam logic [W-1:0] EXP_SUB = {16'd65530, 16'd65535, 16'd65534, 16'd65528, 16'd65530, 16'd65525, 16'd65523, 16'd5, 16'd9};
  localparam logic [W-1:0] EXP_TRN = {16'd1, 16'd4, 16'd7, 16'd2, 16'd5, 16'd8, 16'd3, 16'd6, 16'd9};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] EXP_OVF = {16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3};

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic [W-1:0] sb[$];

  matrix_calc_sequencer_if #(.DW(DW), .DIM(DIM)) bus ();

  matrix_calc_sequencer #(.DW(DW), .DIM(DIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareValue(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Offer a request, hold it until accepted, then scramble the bus to prove capture
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] exp,
                               input bit push);
    int n;
    logic [159:0] junk;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) compareValue("accept_timeout", W'(bus.in_ready), W'(1));
    @(posedge clk);
    #1;
    junk = {$urandom, $urandom, $urandom, $urandom, $urandom};
    bus.in_valid = 1'b0;
    bus.in_a     = junk[143:0];
    bus.in_b     = ~junk[143:0];
    bus.in_op    = 2'($urandom);
    if (push) sb.push_back(exp);
    compareValue("busy_after_accept", W'(bus.busy), W'(1));
    compareValue("in_ready_low_in_run", W'(bus.in_ready), W'(0));
  endtask

  // Wait for the result, check latency and value, optionally stall the consumer
  task automatic checkOutput(input string tag, input int lat, input int hold);
    int n;
    logic [W-1:0] exp;
    bus.out_ready = (hold == 0);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    compareValue({tag, "_latency"}, W'(n), W'(lat));
    if (sb.size() == 0) begin
      compareValue({tag, "_scoreboard_empty"}, W'(0), W'(1));
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    compareValue({tag, "_result"}, bus.out_result, exp);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      compareValue({tag, "_hold_valid"}, W'(bus.out_valid), W'(1));
      compareValue({tag, "_hold_result"}, bus.out_result, exp);
      compareValue({tag, "_hold_in_ready"}, W'(bus.in_ready), W'(0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    compareValue({tag, "_idle_in_ready"}, W'(bus.in_ready), W'(1));
    compareValue({tag, "_idle_out_valid"}, W'(bus.out_valid), W'(0));
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compareValue("reset_in_ready", W'(bus.in_ready), W'(1));
    compareValue("reset_out_valid", W'(bus.out_valid), W'(0));
    compareValue("reset_busy", W'(bus.busy), W'(0));
    compareValue("reset_result", bus.out_result, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(OP_MUL, MAT_A, MAT_B, EXP_MUL, 1'b1);
    checkOutput("mul", 27, 0);

    applyStimulus(OP_ADD, MAT_A, MAT_B, EXP_ADD, 1'b1);
    checkOutput("add", 9, 0);

    applyStimulus(OP_SUB, MAT_A, MAT_B, EXP_SUB, 1'b1);
    checkOutput("sub", 9, 0);

    applyStimulus(OP_MUL, ALL_ONES, ALL_ONES, EXP_OVF, 1'b1);
    checkOutput("mul_overflow", 27, 0);

    applyStimulus(OP_TRN, MAT_A, MAT_B, EXP_TRN, 1'b1);
    checkOutput("trn_backpressure", 9, 10);

    applyStimulus(OP_MUL, MAT_A, MAT_B, EXP_MUL, 1'b0);
    repeat (11) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    compareValue("midrun_reset_in_ready", W'(bus.in_ready), W'(1));
    compareValue("midrun_reset_out_valid", W'(bus.out_valid), W'(0));
    compareValue("midrun_reset_busy", W'(bus.busy), W'(0));
    compareValue("midrun_reset_result", bus.out_result, '0);
    rst = 1'b0;

    applyStimulus(OP_ADD, MAT_A, MAT_B, EXP_ADD, 1'b1);
    checkOutput("add_after_reset", 9, 0);

    compareValue("scoreboard_drained", W'(sb.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
